game_frame_renderer: RTL and testbench

Pixel-stream consumer that sits directly downstream of the game logic controller and upstream of the HDMI TMDS encoders. It converts the annotated stream (wall / person / collision flags, wall depth, game state) plus the aligned camera pixel into final RGB888 video. It draws a depth progress HUD and a win/lose flashing border. It also reports a per-frame count of collision pixels.

---
 rtl/game_pkg.sv | 47 ++++
 rtl/game_frame_renderer_if.sv | 36 +++
 rtl/frame_collision_accumulator.sv | 43 ++++
 rtl/game_frame_renderer.sv | 160 ++++++++++++++++
 tb/tb_game_frame_renderer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the frame renderer: game-state encoding,
// render modes, colours, stream widths and the RGB565 expansion helper.
package game_pkg;

  localparam int unsigned HCOUNT_W  = 11;
  localparam int unsigned VCOUNT_W  = 10;
  localparam int unsigned DEPTH_W   = 8;
  localparam int unsigned GSTATE_W  = 3;
  localparam int unsigned CAM_W     = 16;
  localparam int unsigned RGB_W     = 24;
  localparam int unsigned COLL_W    = 20;
  localparam int unsigned HUD_LEN_W = 12;

  localparam int unsigned DEFAULT_SCREEN_WIDTH  = 1280;
  localparam int unsigned DEFAULT_SCREEN_HEIGHT = 720;

  typedef enum logic [GSTATE_W-1:0] {
    GS_LOST    = 3'd0,
    GS_PLAYING = 3'd1,
    GS_WON     = 3'd2
  } game_state_e;

  typedef enum logic [1:0] {
    MODE_PLAY = 2'd0,
    MODE_WIN  = 2'd1,
    MODE_LOSE = 2'd2
  } render_mode_t;

  localparam logic [RGB_W-1:0] COL_RED    = 24'hFF0000;
  localparam logic [RGB_W-1:0] COL_GREEN  = 24'h00FF00;
  localparam logic [RGB_W-1:0] COL_WHITE  = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] COL_YELLOW = 24'hFFFF00;

  // One pixel beat travelling down the output pipeline
  typedef struct packed {
    logic                valid;
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic [RGB_W-1:0]    pixel;
  } stream_beat_t;

  // RGB565 -> RGB888 by replicating each channel's MSBs into the low bits
  function automatic logic [RGB_W-1:0] expand565(input logic [CAM_W-1:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/game_frame_renderer_if.sv
// Annotated pixel stream in, rendered RGB888 stream and frame stats out.
interface game_frame_renderer_if;
  import game_pkg::*;

  logic [HCOUNT_W-1:0] hcount_in;
  logic [VCOUNT_W-1:0] vcount_in;
  logic                data_valid_in;
  logic [CAM_W-1:0]    camera_pixel_in;
  logic                is_wall_in;
  logic                is_person_in;
  logic                is_collision_in;
  logic [DEPTH_W-1:0]  wall_depth_in;
  logic [GSTATE_W-1:0] game_state_in;

  logic [HCOUNT_W-1:0] hcount_out;
  logic [VCOUNT_W-1:0] vcount_out;
  logic                data_valid_out;
  logic [RGB_W-1:0]    pixel_out;
  logic [COLL_W-1:0]   frame_collisions_out;
  logic                frame_done_out;

  modport slave (
    input  hcount_in, vcount_in, data_valid_in, camera_pixel_in,
           is_wall_in, is_person_in, is_collision_in, wall_depth_in, game_state_in,
    output hcount_out, vcount_out, data_valid_out, pixel_out,
           frame_collisions_out, frame_done_out
  );

  modport master (
    output hcount_in, vcount_in, data_valid_in, camera_pixel_in,
           is_wall_in, is_person_in, is_collision_in, wall_depth_in, game_state_in,
    input  hcount_out, vcount_out, data_valid_out, pixel_out,
           frame_collisions_out, frame_done_out
  );

endinterface

// File: rtl/frame_collision_accumulator.sv
// Saturating per-frame collision counter; latches the total and pulses done at EOF.
module frame_collision_accumulator #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             hit_i,
  input  logic             eof_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q;
  logic             done_q;

  // Running sum including the current pixel, held at all-ones once full
  always_comb begin
    acc_d = acc_q;
    if (hit_i && (acc_q != {CNT_W{1'b1}})) acc_d = acc_q + CNT_W'(1);
  end

  // Accumulate; at EOF publish the total (EOF pixel included) and restart
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= eof_i;
      if (eof_i) begin
        count_q <= acc_d;
        acc_q   <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end
  end

  assign count_o = count_q;
  assign done_o  = done_q;

endmodule

// File: rtl/game_frame_renderer.sv
// Final video compositor: HUD, win/lose blinking border, wall/person/collision
// colouring over the camera image, plus per-frame collision statistics.
module game_frame_renderer
  import game_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH       = DEFAULT_SCREEN_WIDTH,
  parameter int unsigned SCREEN_HEIGHT      = DEFAULT_SCREEN_HEIGHT,
  parameter int unsigned GOAL_DEPTH         = 60,
  parameter int unsigned GOAL_DEPTH_DELTA   = 10,
  parameter int unsigned HUD_HEIGHT         = 16,
  parameter int unsigned HUD_SCALE          = 16,
  parameter int unsigned BORDER             = 8,
  parameter int unsigned BLINK_FRAMES       = 15,
  parameter int unsigned RESULT_HOLD_FRAMES = 120
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  game_frame_renderer_if.slave  bus
);

  localparam int unsigned HOLD_W  = $clog2(RESULT_HOLD_FRAMES + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [HCOUNT_W-1:0]  H_LAST    = HCOUNT_W'(SCREEN_WIDTH - 1);
  localparam logic [VCOUNT_W-1:0]  V_LAST    = VCOUNT_W'(SCREEN_HEIGHT - 1);
  localparam logic [HCOUNT_W-1:0]  BORDER_H  = HCOUNT_W'(BORDER);
  localparam logic [HCOUNT_W-1:0]  BORDER_HR = HCOUNT_W'(SCREEN_WIDTH - BORDER);
  localparam logic [VCOUNT_W-1:0]  BORDER_V  = VCOUNT_W'(BORDER);
  localparam logic [VCOUNT_W-1:0]  BORDER_VB = VCOUNT_W'(SCREEN_HEIGHT - BORDER);
  localparam logic [VCOUNT_W-1:0]  HUD_V     = VCOUNT_W'(HUD_HEIGHT);
  localparam logic [HUD_LEN_W-1:0] GOAL_LO   = HUD_LEN_W'((GOAL_DEPTH - GOAL_DEPTH_DELTA) * HUD_SCALE);
  localparam logic [HUD_LEN_W-1:0] GOAL_HI   = HUD_LEN_W'((GOAL_DEPTH + GOAL_DEPTH_DELTA) * HUD_SCALE);
  localparam logic [HOLD_W-1:0]    HOLD_THR  = HOLD_W'(RESULT_HOLD_FRAMES);
  localparam logic [HOLD_W-1:0]    HOLD_MAX  = {HOLD_W{1'b1}};
  localparam logic [BLINK_W-1:0]   BLINK_END = BLINK_W'(BLINK_FRAMES - 1);

  render_mode_t       mode_q, mode_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;

  logic               eof_c;
  logic [RGB_W-1:0]   cam888_c;
  logic [RGB_W-1:0]   pix_c;
  logic [HUD_LEN_W-1:0] hud_len_c;
  logic [HUD_LEN_W-1:0] h_wide_c;
  logic [9:0]         wall_sum_c;
  logic [7:0]         wall_b_c;
  logic               border_c;
  logic               hud_row_c;

  stream_beat_t       s1_d, s1_q, s2_q;

  assign eof_c = bus.data_valid_in && (bus.hcount_in == H_LAST) && (bus.vcount_in == V_LAST);

  // Mode, hold and blink registers; they only move at end of frame
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mode_q      <= MODE_PLAY;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  // Next mode at EOF; entering a result screen restarts hold and blink (phase ON)
  always_comb begin
    mode_d      = mode_q;
    hold_d      = hold_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (eof_c) begin
      if (blink_cnt_q == BLINK_END) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
      if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
      unique case (mode_q)
        MODE_PLAY: begin
          if (bus.game_state_in == GS_LOST)     mode_d = MODE_LOSE;
          else if (bus.game_state_in == GS_WON) mode_d = MODE_WIN;
        end
        MODE_WIN, MODE_LOSE: begin
          if ((bus.game_state_in == GS_PLAYING) && (hold_q >= HOLD_THR)) mode_d = MODE_PLAY;
        end
        default: mode_d = MODE_PLAY;
      endcase
      if ((mode_q == MODE_PLAY) && (mode_d != MODE_PLAY)) begin
        hold_d      = '0;
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
      end
    end
  end

  // Pixel colour by priority: border, HUD, collision, wall, person, camera
  always_comb begin
    cam888_c   = expand565(bus.camera_pixel_in);
    hud_len_c  = HUD_LEN_W'(bus.wall_depth_in) * HUD_LEN_W'(HUD_SCALE);
    h_wide_c   = HUD_LEN_W'(bus.hcount_in);
    wall_sum_c = 10'h040 + {1'b0, bus.wall_depth_in, 1'b0};
    wall_b_c   = (wall_sum_c > 10'h0FF) ? 8'hFF : wall_sum_c[7:0];
    border_c   = (bus.hcount_in < BORDER_H) || (bus.hcount_in >= BORDER_HR) ||
                 (bus.vcount_in < BORDER_V) || (bus.vcount_in >= BORDER_VB);
    hud_row_c  = (mode_q == MODE_PLAY) && (bus.vcount_in < HUD_V);
    pix_c      = cam888_c;
    if (!bus.data_valid_in) begin
      pix_c = '0;
    end else if ((mode_q != MODE_PLAY) && border_c && blink_on_q) begin
      pix_c = (mode_q == MODE_WIN) ? COL_GREEN : COL_RED;
    end else if (hud_row_c && (h_wide_c < hud_len_c)) begin
      pix_c = COL_WHITE;
    end else if (hud_row_c && (h_wide_c >= GOAL_LO) && (h_wide_c < GOAL_HI)) begin
      pix_c = COL_YELLOW;
    end else if (bus.is_collision_in) begin
      pix_c = COL_RED;
    end else if (bus.is_wall_in) begin
      pix_c = {16'h0000, wall_b_c};
    end else if (bus.is_person_in) begin
      pix_c = {1'b0, cam888_c[23:17], cam888_c[15:8] | 8'h80, 1'b0, cam888_c[7:1]};
    end
  end

  assign s1_d = {bus.data_valid_in, bus.hcount_in, bus.vcount_in, pix_c};

  // Two-stage output pipeline
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s1_q;
    end
  end

  assign bus.hcount_out     = s2_q.hcount;
  assign bus.vcount_out     = s2_q.vcount;
  assign bus.data_valid_out = s2_q.valid;
  assign bus.pixel_out      = s2_q.pixel;

  frame_collision_accumulator #(
    .CNT_W (COLL_W)
  ) u_acc (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .hit_i   (bus.data_valid_in && bus.is_collision_in),
    .eof_i   (eof_c),
    .count_o (bus.frame_collisions_out),
    .done_o  (bus.frame_done_out)
  );

endmodule

// File: tb/tb_game_frame_renderer.sv
// Directed bench for game_frame_renderer with an in-order pixel scoreboard.
module tb_game_frame_renderer;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_COLL = 3'b100;
  localparam logic [2:0] F_WALL = 3'b010;
  localparam logic [2:0] F_PERS = 3'b001;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic [23:0] pix;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t q[$];

  game_frame_renderer_if bus ();

  game_frame_renderer dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus.data_valid_in   = 1'b0;
    bus.hcount_in       = '0;
    bus.vcount_in       = '0;
    bus.camera_pixel_in = '0;
    bus.is_wall_in      = 1'b0;
    bus.is_person_in    = 1'b0;
    bus.is_collision_in = 1'b0;
    bus.wall_depth_in   = '0;
    bus.game_state_in   = 3'd1;
  endtask

  task automatic idle();
    @(negedge clk);
    set_idle();
  endtask

  // Invalid cycle carrying a collision flag at the EOF coordinates
  task automatic gap_coll();
    @(negedge clk);
    set_idle();
    bus.hcount_in       = 11'd1279;
    bus.vcount_in       = 10'd719;
    bus.is_collision_in = 1'b1;
  endtask

  task automatic pix(input logic [10:0] h, input logic [9:0] v, input logic [15:0] cam,
                     input logic [2:0] fl, input logic [7:0] depth, input logic [2:0] gs,
                     input logic [23:0] exp);
    @(negedge clk);
    bus.data_valid_in   = 1'b1;
    bus.hcount_in       = h;
    bus.vcount_in       = v;
    bus.camera_pixel_in = cam;
    bus.is_collision_in = fl[2];
    bus.is_wall_in      = fl[1];
    bus.is_person_in    = fl[0];
    bus.wall_depth_in   = depth;
    bus.game_state_in   = gs;
    q.push_back('{h: h, v: v, pix: exp});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pixel"}, 32'(bus.pixel_out), 32'd0);
    check({tag, "_dv"},    32'(bus.data_valid_out), 32'd0);
    check({tag, "_h"},     32'(bus.hcount_out), 32'd0);
    check({tag, "_v"},     32'(bus.vcount_out), 32'd0);
    check({tag, "_cnt"},   32'(bus.frame_collisions_out), 32'd0);
    check({tag, "_done"},  32'(bus.frame_done_out), 32'd0);
  endtask

  // Result screen: 121 frames; gs returns to PLAYING from frame 50 but only
  // the EOF of frame 120 (hold reaching the threshold) releases the mode
  task automatic result_frames(input logic is_win, input logic [2:0] entry_gs);
    logic        on;
    logic [23:0] col;
    col = is_win ? 24'h00FF00 : 24'hFF0000;
    for (int k = 0; k <= 120; k++) begin
      on = (((k / 15) % 2) == 0);
      pix(11'd0,    10'd0,   16'h001F, F_NONE, 8'd0,  3'd1, on ? col : 24'h0000FF);
      pix(11'd640,  10'd360, 16'h8410, F_NONE, 8'd0,  3'd1, 24'h848284);
      pix(11'd100,  10'd10,  16'h8410, F_NONE, 8'd20, 3'd1, 24'h848284);
      pix(11'd1279, 10'd719, 16'h001F, F_NONE, 8'd0,
          (k < 50) ? entry_gs : 3'd1, on ? col : 24'h0000FF);
    end
    pix(11'd0, 10'd0, 16'h001F, F_NONE, 8'd5, 3'd1, 24'hFFFFFF);
    pix(11'd0, 10'd0, 16'h001F, F_NONE, 8'd0, 3'd1, 24'h0000FF);
  endtask

  // Scoreboard: pop one expectation per valid output beat
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.data_valid_out) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_underflow: observed=unexpected beat h=%0d v=%0d expected=none",
                 bus.hcount_out, bus.vcount_out);
        end else begin
          e = q.pop_front();
          check("sb_hcount", 32'(bus.hcount_out), 32'(e.h));
          check("sb_vcount", 32'(bus.vcount_out), 32'(e.v));
          check("sb_pixel",  32'(bus.pixel_out),  32'(e.pix));
        end
      end else begin
        check("idle_pixel_zero", 32'(bus.pixel_out), 32'd0);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_idle();
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;

    // Mid-frame asynchronous reset
    pix(11'd10, 10'd100, 16'h1234, F_NONE, 8'd0, 3'd1, 24'h1045A5);
    pix(11'd11, 10'd100, 16'h1234, F_COLL, 8'd0, 3'd1, 24'hFF0000);
    pix(11'd12, 10'd100, 16'h1234, F_COLL, 8'd0, 3'd1, 24'hFF0000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    q.delete();
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Two-cycle latency
    pix(11'd20, 10'd200, 16'hF800, F_NONE, 8'd0, 3'd1, 24'hFF0000);
    idle();
    check("lat1_dv", 32'(bus.data_valid_out), 32'd0);
    idle();
    check("lat2_dv",  32'(bus.data_valid_out), 32'd1);
    check("lat2_pix", 32'(bus.pixel_out), 32'hFF0000);

    // Wall, collision, person, camera expansion
    pix(11'd640, 10'd360, 16'h1234, F_WALL,          8'd10,  3'd1, 24'h000054);
    pix(11'd640, 10'd360, 16'h1234, F_WALL | F_COLL, 8'd10,  3'd1, 24'hFF0000);
    pix(11'd640, 10'd360, 16'hF800, F_PERS,          8'd0,   3'd1, 24'h7F8000);
    pix(11'd640, 10'd360, 16'h8410, F_PERS,          8'd0,   3'd1, 24'h428242);
    pix(11'd640, 10'd360, 16'h1234, F_WALL | F_PERS, 8'd10,  3'd1, 24'h000054);
    pix(11'd640, 10'd360, 16'h1234, F_WALL,          8'd95,  3'd1, 24'h0000FE);
    pix(11'd640, 10'd360, 16'h1234, F_WALL,          8'd96,  3'd1, 24'h0000FF);
    pix(11'd640, 10'd360, 16'h1234, F_WALL,          8'd200, 3'd1, 24'h0000FF);
    pix(11'd640, 10'd360, 16'hFFFF, F_NONE,          8'd0,   3'd1, 24'hFFFFFF);
    pix(11'd640, 10'd360, 16'h0841, F_NONE,          8'd0,   3'd1, 24'h080808);
    pix(11'd0,   10'd400, 16'h8410, F_NONE,          8'd0,   3'd1, 24'h848284);
    gap_coll();

    // HUD bar and goal window
    pix(11'd319,  10'd5,  16'h8410, F_NONE, 8'd20,  3'd1, 24'hFFFFFF);
    pix(11'd320,  10'd5,  16'h8410, F_NONE, 8'd20,  3'd1, 24'h848284);
    pix(11'd800,  10'd5,  16'h8410, F_NONE, 8'd20,  3'd1, 24'hFFFF00);
    pix(11'd1119, 10'd5,  16'h8410, F_NONE, 8'd20,  3'd1, 24'hFFFF00);
    pix(11'd1120, 10'd5,  16'h8410, F_NONE, 8'd20,  3'd1, 24'h848284);
    pix(11'd1200, 10'd5,  16'h8410, F_NONE, 8'd20,  3'd1, 24'h848284);
    pix(11'd319,  10'd16, 16'h8410, F_NONE, 8'd20,  3'd1, 24'h848284);
    pix(11'd100,  10'd5,  16'h8410, F_COLL, 8'd20,  3'd1, 24'hFFFFFF);
    pix(11'd900,  10'd15, 16'h8410, F_WALL, 8'd20,  3'd1, 24'hFFFF00);
    pix(11'd100,  10'd5,  16'h8410, F_NONE, 8'd0,   3'd1, 24'h848284);
    pix(11'd1279, 10'd0,  16'h8410, F_NONE, 8'd255, 3'd1, 24'hFFFFFF);

    // First EOF after reset: only the two post-reset collisions count
    pix(11'd1279, 10'd719, 16'h001F, F_NONE, 8'd0, 3'd1, 24'h0000FF);
    idle();
    check("eof1_done", 32'(bus.frame_done_out), 32'd1);
    check("eof1_cnt",  32'(bus.frame_collisions_out), 32'd2);
    idle();
    check("eof1_done_pulse", 32'(bus.frame_done_out), 32'd0);

    // 1000 collisions, the last one on the EOF pixel
    for (int i = 0; i < 999; i++) begin
      if ((i % 250) == 0) gap_coll();
      pix(11'(i), 10'd400, 16'h1234, F_COLL, 8'd0, 3'd1, 24'hFF0000);
    end
    check("c1000_no_early_done", 32'(bus.frame_done_out), 32'd0);
    pix(11'd1279, 10'd719, 16'h1234, F_COLL, 8'd0, 3'd1, 24'hFF0000);
    idle();
    check("c1000_done", 32'(bus.frame_done_out), 32'd1);
    check("c1000_cnt",  32'(bus.frame_collisions_out), 32'd1000);
    idle();
    check("c1000_done_pulse", 32'(bus.frame_done_out), 32'd0);
    check("c1000_cnt_hold",   32'(bus.frame_collisions_out), 32'd1000);

    // WIN then back to PLAY
    pix(11'd1279, 10'd719, 16'h001F, F_NONE, 8'd0, 3'd2, 24'h0000FF);
    result_frames(1'b1, 3'd2);

    // LOSE then back to PLAY
    pix(11'd1279, 10'd719, 16'h001F, F_NONE, 8'd0, 3'd0, 24'h0000FF);
    pix(11'd640,  10'd715, 16'h001F, F_NONE, 8'd0, 3'd1, 24'hFF0000);
    result_frames(1'b0, 3'd0);

    // Counter saturation: preload near full, then 2^20+5 total
    idle();
    force dut.u_acc.acc_q = 20'hFFFFA;
    #1 release dut.u_acc.acc_q;
    for (int i = 0; i < 10; i++)
      pix(11'd5, 10'd500, 16'h1234, F_COLL, 8'd0, 3'd1, 24'hFF0000);
    pix(11'd1279, 10'd719, 16'h1234, F_COLL, 8'd0, 3'd1, 24'hFF0000);
    idle();
    check("sat_done", 32'(bus.frame_done_out), 32'd1);
    check("sat_cnt",  32'(bus.frame_collisions_out), 32'hFFFFF);

    // Drain the pipeline within a bounded number of cycles
    for (int i = 0; i < 20 && q.size() != 0; i++) idle();
    check("sb_drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
